spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DIV, default 4, SCK half-period in PCLK cycles; legal range 2..255.
REQ-002 PCLK  input  1  system clock; all state updates on rising edge.
REQ-003 PRESET  input  1  reset; synchronous, active-high.
REQ-004 START  input  1  transfer request, sampled only in IDLE.
REQ-005 TX_DATA  input  8  byte to transmit MSB-first; captured on the accepting edge.
REQ-006 MISO  input  1  serial data from slave.
REQ-007 SCK  output  1  serial clock, mode 0 (CPOL=0, CPHA=0), registered.
REQ-008 SS  output  1  slave select, active-low, registered.
REQ-009 MOSI  output  1  serial data to slave, registered.
REQ-010 RX_DATA  output  8  last completed received byte.
REQ-011 BUSY  output  1  high from accepting edge until DONE cycle inclusive.
REQ-012 DONE  output  1  one-cycle pulse at transfer completion.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, DONE; one half-period counter (0..DIV-1) and one 4-bit edge counter.
REQ-014 IDLE: SS=1, SCK=0, MOSI=0, BUSY=0; START=1 at edge E0 -> load TX_DATA to TX shift reg, go SETUP, SS=0, MOSI=TX_DATA[7], BUSY=1.
REQ-015 SETUP: SCK=0 for DIV cycles; at edge E0+DIV SCK goes 1, go SHIFT.
REQ-016 SHIFT: SCK toggles every DIV cycles; rising edges at E0+(2k+1)*DIV, falling at E0+(2k+2)*DIV, k=0..7.
REQ-017 On each PCLK edge that drives SCK 0->1, MISO SHALL be shifted into RX shift reg LSB, shifting left (first sample -> final bit 7).
REQ-018 On falling edges 1..7, MOSI SHALL advance to next TX bit (bit6..bit0); on the 8th falling edge (E0+16*DIV) MOSI=0, go HOLD.
REQ-019 HOLD: SCK=0, SS=0 for DIV cycles; at E0+17*DIV go DONE: SS=1, DONE=1, RX_DATA <= RX shift reg.
REQ-020 DONE lasts exactly one cycle, BUSY=1 during it, then IDLE; START during DONE SHALL be ignored, so SS high for at least 2 cycles between transfers.
REQ-021 Exactly 8 SCK rising and 8 falling edges per transfer; SCK never toggles while SS=1.
REQ-022 START while not in IDLE SHALL be ignored; TX_DATA changes after accept SHALL not affect the transfer.
REQ-023 RX_DATA SHALL hold its value between DONE pulses; updated only in DONE.
REQ-024 All outputs SHALL be registered; no combinational path from MISO or START to any output.

Reset
REQ-025 PRESET=1 at any edge SHALL force IDLE, SS=1, SCK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0x00, counters and shift regs 0.
REQ-026 Reset mid-transfer SHALL abort with no DONE pulse and RX_DATA=0x00.
REQ-027 PRESET and START in the same cycle: reset wins, START not accepted.

Verification
REQ-028 DIV=2, MISO tied to MOSI, TX_DATA=0xA5 -> DONE 34 cycles after accept, RX_DATA=0xA5, MOSI sequence 1,0,1,0,0,1,0,1 changing only on SCK fall.
REQ-029 DIV=4, MISO tied 1, TX_DATA=0x00 -> RX_DATA=0xFF, 8 SCK pulses each 4 high/4 low cycles, DONE 68 cycles after accept.
REQ-030 START held high continuously, TX_DATA 0x3C then 0xC3, loopback -> two transfers, RX_DATA 0x3C then 0xC3, SS high exactly 2 cycles between them.
REQ-031 PRESET pulsed after 3rd SCK rise of a 0xFF transfer -> next cycle SS=1, SCK=0, BUSY=0, RX_DATA=0x00, no DONE.
REQ-032 START pulsed and TX_DATA changed to 0x00 mid-transfer of 0x81 -> ignored, MOSI still sends 0x81, single DONE.
REQ-033 Slave model (mode 0, sample MOSI on SCK rise, shift on fall, preloaded 0x5A) -> master RX_DATA=0x5A, slave output 0xA5 for TX_DATA=0xA5.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transfer, MSB first, SCK half-period of DIV clocks.
// All outputs come straight from flops.
module spi_master #(
    parameter int DIV = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    input  logic       MISO,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DIV - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] edge_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] rx_data_q;
    logic       sck_q;
    logic       ss_q;
    logic       mosi_q;
    logic       busy_q;
    logic       done_q;
    logic       half_done;

    assign half_done = (cnt_q == CNT_MAX);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            edge_q    <= 4'd0;
            tx_q      <= 8'd0;
            rx_q      <= 8'd0;
            rx_data_q <= 8'd0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q <= S_SETUP;
                        tx_q    <= TX_DATA;
                        mosi_q  <= TX_DATA[7];
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        edge_q  <= 4'd0;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        // First SCK rise: sample MISO on the same clock that raises SCK.
                        cnt_q   <= 8'd0;
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], MISO};
                        edge_q  <= 4'd1;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (half_done) begin
                        cnt_q <= 8'd0;
                        sck_q <= ~sck_q;
                        if (sck_q) begin
                            // edge_q == 15 marks the eighth falling edge.
                            if (edge_q == 4'd15) begin
                                mosi_q  <= 1'b0;
                                edge_q  <= 4'd0;
                                state_q <= S_HOLD;
                            end else begin
                                mosi_q <= tx_q[6];
                                tx_q   <= {tx_q[6:0], 1'b0};
                                edge_q <= edge_q + 4'd1;
                            end
                        end else begin
                            rx_q   <= {rx_q[6:0], MISO};
                            edge_q <= edge_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        cnt_q     <= 8'd0;
                        ss_q      <= 1'b1;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_q;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SCK     = sck_q;
    assign SS      = ss_q;
    assign MOSI    = mosi_q;
    assign RX_DATA = rx_data_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: random and directed transfers against a mode-0 slave or loopback,
// with a cycle-accurate pin model derived from the transfer timeline.
module tb_spi_master;

    localparam int D = 4;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       START;
    logic [7:0] TX_DATA;
    logic       MISO;
    logic       SCK, SS, MOSI, BUSY, DONE;
    logic [7:0] RX_DATA;

    spi_master #(.DIV(D)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .START(START), .TX_DATA(TX_DATA), .MISO(MISO),
        .SCK(SCK), .SS(SS), .MOSI(MOSI), .RX_DATA(RX_DATA), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Mode-0 slave: drive MSB when selected, shift on SCK fall, sample MOSI on SCK rise.
    logic [7:0] sl_pre = 8'h00;
    logic [7:0] sl_sh = 8'h00;
    logic [7:0] sl_rx = 8'h00;
    logic       loop = 1'b0;
    logic       ss_prev = 1'b1;
    logic       sck_prev = 1'b0;

    always @(SS or SCK) begin
        if (ss_prev === 1'b1 && SS === 1'b0)
            sl_sh = sl_pre;
        else if (sck_prev === 1'b1 && SCK === 1'b0 && SS === 1'b0)
            sl_sh = {sl_sh[6:0], 1'b0};
        ss_prev  = SS;
        sck_prev = SCK;
    end

    always @(posedge SCK) sl_rx <= {sl_rx[6:0], MOSI};

    assign MISO = loop ? MOSI : sl_sh[7];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sb;
        int         acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] exp_rx = 8'h00;

    // Pin-level model: t counts clocks since the accepting edge of the current transfer.
    int t;
    int idx;
    bit act;
    bit e_ss, e_sck, e_mosi, e_busy, e_done;

    always @(posedge PCLK) begin
        #1;
        if (PRESET === 1'b1) begin
            q.delete();
            exp_rx = 8'h00;
        end
        act = (q.size() > 0) && (cyc >= q[0].acc);
        t   = act ? (cyc - q[0].acc) : 0;
        e_ss   = !(act && t < 17 * D);
        e_sck  = act && ((t / D) % 2 == 1) && (t < 16 * D);
        e_busy = act && (t <= 17 * D);
        e_done = act && (t == 17 * D);
        e_mosi = 1'b0;
        if (act && t < 16 * D) begin
            idx    = 7 - t / (2 * D);
            e_mosi = q[0].tx[idx];
        end
        chk("SS", SS, e_ss);
        chk("SCK", SCK, e_sck);
        chk("MOSI", MOSI, e_mosi);
        chk("BUSY", BUSY, e_busy);
        chk("DONE", DONE, e_done);
        if (e_done) begin
            chk("RX_DATA at DONE", RX_DATA, q[0].sb);
            chk("slave received", sl_rx, q[0].tx);
            exp_rx = q[0].sb;
            void'(q.pop_front());
        end else begin
            chk("RX_DATA hold", RX_DATA, exp_rx);
        end
    end

    int free_at = 0;
    int last_acc = 0;

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge PCLK);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input bit lb, input int gap);
        exp_t e;
        wait_until(free_at + gap);
        loop     = lb;
        TX_DATA  = tx;
        sl_pre   = sb;
        START    = 1'b1;
        last_acc = cyc + 1;
        e.tx  = tx;
        e.sb  = lb ? tx : sb;
        e.acc = last_acc;
        q.push_back(e);
        free_at = last_acc + 17 * D + 1;
        @(negedge PCLK);
        START = 1'b0;
    endtask

    task automatic do_reset(input bit with_start);
        PRESET  = 1'b1;
        START   = with_start;
        TX_DATA = 8'($urandom_range(0, 255));
        @(negedge PCLK);
        PRESET  = 1'b0;
        START   = 1'b0;
        free_at = cyc;
    endtask

    initial begin
        exp_t e;
        int   a1, a2;
        PRESET  = 1'b1;
        START   = 1'b0;
        TX_DATA = 8'h00;
        repeat (3) @(negedge PCLK);
        PRESET  = 1'b0;
        free_at = cyc;

        for (int i = 0; i < 12; i++)
            xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0,
                 $urandom_range(0, 5));

        xfer(8'hA5, 8'h00, 1'b1, 0);
        xfer(8'hA5, 8'h5A, 1'b0, 2);
        xfer(8'h00, 8'hFF, 1'b0, 0);

        // START during the DONE cycle must be ignored.
        xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 0);
        wait_until(last_acc + 17 * D);
        TX_DATA = 8'($urandom_range(0, 255));
        START   = 1'b1;
        @(negedge PCLK);
        START   = 1'b0;

        // START plus TX_DATA change mid-transfer must be ignored.
        xfer(8'h81, 8'($urandom_range(0, 255)), 1'b0, 1);
        wait_until(last_acc + 7 * D);
        TX_DATA = 8'h00;
        START   = 1'b1;
        @(negedge PCLK);
        START   = 1'b0;

        // START held high: two back-to-back loopback transfers.
        wait_until(free_at + 1);
        loop    = 1'b1;
        TX_DATA = 8'h3C;
        START   = 1'b1;
        a1      = cyc + 1;
        e.tx = 8'h3C; e.sb = 8'h3C; e.acc = a1;
        q.push_back(e);
        @(negedge PCLK);
        TX_DATA = 8'hC3;
        a2      = a1 + 17 * D + 2;
        e.tx = 8'hC3; e.sb = 8'hC3; e.acc = a2;
        q.push_back(e);
        wait_until(a2);
        START   = 1'b0;
        free_at = a2 + 17 * D + 1;

        // Reset after the third SCK rise of a 0xFF transfer aborts it.
        xfer(8'hFF, 8'h5A, 1'b0, 0);
        xfer(8'hFF, 8'($urandom_range(0, 255)), 1'b0, 0);
        wait_until(last_acc + 5 * D);
        do_reset(1'b0);
        repeat (4) @(negedge PCLK);

        // Reset and START together: reset wins.
        do_reset(1'b1);
        repeat (3) @(negedge PCLK);
        xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 0);

        for (int k = 0; k < 2000 && q.size() > 0; k++) @(negedge PCLK);
        chk("pending transfers at end", q.size(), 0);
        repeat (3) @(negedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
